// File: rtl/game_end_ctrl.sv
// game_end_ctrl: PLAY/WIN/LOSE sequencer driving end-text overlay and game reset pulse.
// Define GAME_END_BLINK_EN to make the end text blink; otherwise it stays steadily on.
module game_end_ctrl #(
  parameter int BLINK_FRAMES = 30,
  parameter int HOLD_FRAMES  = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       start,
  input  logic [3:0] hp_in,
  input  logic       item2,
  output logic [2:0] state,
  output logic       show_win,
  output logic       show_lose,
  output logic       text_on,
  output logic       game_rst
);
  localparam int HW = HOLD_FRAMES > 1 ? $clog2(HOLD_FRAMES) : 1;
  typedef enum logic [2:0] {IDLE = 3'd0, PLAY = 3'd1, WIN = 3'd2, LOSE = 3'd3, RESTART = 3'd4} state_e;
  state_e state_q;
  logic [HW-1:0] hold_q;
  logic start_q, vsync_q, show_win_q, show_lose_q, text_on_q, game_rst_q;
`ifdef GAME_END_BLINK_EN
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] blink_q;
`endif
  logic start_edge, frame_tick, timeout;
  assign start_edge = start & ~start_q;
  assign frame_tick = vsync & ~vsync_q;
  assign timeout    = frame_tick && hold_q == HW'(HOLD_FRAMES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      start_q     <= 1'b0;
      vsync_q     <= 1'b0;
      show_win_q  <= 1'b0;
      show_lose_q <= 1'b0;
      text_on_q   <= 1'b0;
      game_rst_q  <= 1'b0;
`ifdef GAME_END_BLINK_EN
      blink_q     <= '0;
`endif
    end else begin
      start_q    <= start;
      vsync_q    <= vsync;
      game_rst_q <= 1'b0;
      case (state_q)
        IDLE: if (start_edge) state_q <= PLAY;
        PLAY: if (item2 || hp_in == 4'd0) begin
          state_q     <= item2 ? WIN : LOSE;
          show_win_q  <= item2;
          show_lose_q <= ~item2;
          text_on_q   <= 1'b1;
          hold_q      <= '0;
`ifdef GAME_END_BLINK_EN
          blink_q     <= '0;
`endif
        end
        WIN, LOSE: if (start_edge || timeout) begin
          state_q     <= RESTART;
          show_win_q  <= 1'b0;
          show_lose_q <= 1'b0;
          text_on_q   <= 1'b0;
          game_rst_q  <= 1'b1;
        end else if (frame_tick) begin
          hold_q <= hold_q + HW'(1);
`ifdef GAME_END_BLINK_EN
          blink_q   <= blink_q == BW'(BLINK_FRAMES - 1) ? '0 : blink_q + BW'(1);
          text_on_q <= blink_q == BW'(BLINK_FRAMES - 1) ? ~text_on_q : text_on_q;
`endif
        end
        RESTART: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign state     = state_q;
  assign show_win  = show_win_q;
  assign show_lose = show_lose_q;
  assign text_on   = text_on_q;
  assign game_rst  = game_rst_q;
endmodule

// File: tb/tb_game_end_ctrl.sv
// tb_game_end_ctrl: directed and random stimulus scored against a frame-count reference model.
module tb_game_end_ctrl;
  localparam int BLINK = 2;
  localparam int HOLD  = 4;
  logic clk = 1'b0;
  logic rst = 1'b1, vsync = 1'b0, start = 1'b0, item2 = 1'b0;
  logic [3:0] hp_in = 4'd5;
  logic [2:0] state;
  logic show_win, show_lose, text_on, game_rst;
  int n_checks = 0, n_fail = 0;
  int m_state = 0, m_frames = 0;
  bit m_sp = 1'b0, m_vp = 1'b0;
  logic [6:0] exp_q[$];
  game_end_ctrl #(.BLINK_FRAMES(BLINK), .HOLD_FRAMES(HOLD)) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .start(start), .hp_in(hp_in), .item2(item2),
    .state(state), .show_win(show_win), .show_lose(show_lose), .text_on(text_on), .game_rst(game_rst)
  );
  always #5 clk = ~clk;
  function automatic logic expected_text();
    if (m_state != 2 && m_state != 3) return 1'b0;
`ifdef GAME_END_BLINK_EN
    return ((m_frames / BLINK) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction
  task automatic step(input bit r, input bit s, input bit v, input bit [3:0] h, input bit i);
    bit se, ft;
    @(negedge clk);
    rst = r; start = s; vsync = v; hp_in = h; item2 = i;
    se = s & ~m_sp;
    ft = v & ~m_vp;
    if (r) begin
      m_state = 0; m_frames = 0; m_sp = 1'b0; m_vp = 1'b0;
    end else begin
      m_sp = s; m_vp = v;
      if (m_state == 0) begin
        if (se) m_state = 1;
      end else if (m_state == 1) begin
        if (i || h == 0) begin m_state = i ? 2 : 3; m_frames = 0; end
      end else if (m_state == 2 || m_state == 3) begin
        if (se || (ft && m_frames + 1 == HOLD)) m_state = 4;
        else if (ft) m_frames++;
      end else m_state = 0;
    end
    exp_q.push_back({3'(m_state), m_state == 2, m_state == 3, expected_text(), m_state == 4});
  endtask
  task automatic tick(input bit s, input bit [3:0] h, input bit i);
    step(0, s, 1, h, i);
    step(0, s, 0, h, i);
  endtask
  initial begin
    logic [6:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {state, show_win, show_lose, text_on, game_rst};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t got st=%0d win=%b lose=%b txt=%b grst=%b expected st=%0d win=%b lose=%b txt=%b grst=%b",
                   $time, a[6:4], a[3], a[2], a[1], a[0], e[6:4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  end
  initial begin
    bit s = 1'b0, v = 1'b0;
    step(1, 0, 0, 5, 0);
    step(1, 0, 0, 5, 0);
    step(0, 0, 0, 5, 0);
    step(0, 1, 0, 5, 0);
    for (int k = 0; k < 100; k++) step(0, 1, 0, 5, 0);
    step(0, 1, 0, 0, 1);
    for (int k = 0; k < 5; k++) tick(1, 5, 0);
    step(0, 0, 0, 5, 0);
    step(0, 0, 0, 5, 0);
    step(0, 1, 0, 3, 0);
    step(0, 0, 0, 3, 0);
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) tick(0, 5, 0);
    step(0, 1, 0, 5, 0);
    step(0, 0, 0, 5, 0);
    step(0, 0, 0, 5, 1);
    for (int k = 0; k < 3; k++) tick(0, 5, 0);
    tick(1, 5, 0);
    step(0, 0, 0, 5, 0);
    step(0, 0, 0, 5, 0);
    step(0, 1, 0, 5, 0);
    step(0, 0, 0, 5, 1);
    tick(0, 5, 0);
    step(1, 0, 0, 5, 0);
    step(0, 0, 0, 5, 0);
    step(0, 0, 0, 5, 0);
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 7) == 0) s = ~s;
      if ($urandom_range(0, 2) == 0) v = ~v;
      step($urandom_range(0, 199) == 0, s, v,
           $urandom_range(0, 19) == 0 ? 4'd0 : 4'($urandom_range(1, 15)),
           $urandom_range(0, 29) == 0);
    end
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
